serial_addsub: RTL and testbench
================================

# serial_addsub

Parametrised, multi-cycle add/subtract unit that processes `CHUNK` bits per clock over `WIDTH/CHUNK` cycles. It replaces the single-cycle 4-bit `Subtraction` datapath in the arithmetic section wherever wide operands must not form one long carry chain. It produces a registered result plus carry/borrow, signed overflow, zero and negative flags, under a start/busy/done handshake.

## Interface
- `WIDTH`, default 8: operand/result width; must be ≥ 2.
- `CHUNK`, default 2: bits processed per cycle. `WIDTH % CHUNK != 0` is an elaboration error. `N = WIDTH/CHUNK` is the number of compute cycles.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request an operation; sampled only when `busy`=0.
- `sub` input 1: 0 = A+B, 1 = A−B; captured with `start`.
- `A` input WIDTH: first operand; captured with `start`.
- `B` input WIDTH: second operand; captured with `start`.
- `result` output WIDTH: registered sum/difference, modulo 2^WIDTH.
- `carry` output 1: add gives carry-out; sub gives borrow (1 iff A < B unsigned).
- `overflow` output 1: two's-complement signed overflow.
- `zero` output 1: `result` == 0.
- `negative` output 1: `result[WIDTH-1]`.
- `busy` output 1: computation in progress.
- `done` output 1: one-cycle pulse; outputs valid.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE or DONE with `start`=1: latch A, `B ^ {WIDTH{sub}}` and `sub` (as carry-in); clear chunk counter; go to RUN.
- DONE with `start`=0: go to IDLE.
- RUN, each cycle:
  - Add chunk k of the latched operands with the running carry, using a CHUNK-bit adder.
  - Shift the chunk into the internal result shift register, LSB chunk first.
  - Store the carry out.
  - Increment k.
- RUN, after chunk N−1: go to DONE.
- `start` while RUN is ignored. Operands change only when a start is accepted.
- Final values, loaded into the output registers on the edge entering DONE:
  - `result` = shift register.
  - `carry` = cout (add) or ~cout (sub).
  - `overflow` = carry into MSB XOR carry out of MSB.
  - `zero`, `negative` from the final result.
- Output registers hold their values until the next entry into DONE, so they stay stable during a following RUN.
- `busy` = (state == RUN). `done` = (state == DONE).
- Synchronous `rst`, including mid-RUN:
  - Next state is IDLE.
  - All outputs and internal registers go to 0.
  - No `done` is produced for the aborted operation.
  - `rst` has priority over `start`.

## Timing
- `start` sampled high at edge 0: `busy`=1 in cycles 1..N, `done`=1 in cycle N+1.
- Start-to-done latency is N+1 cycles. For N=1, `busy` lasts one cycle.
- Back-to-back: `start` held high during the DONE cycle is accepted. Issue interval is N+1 cycles.
- Throughput is one operation per N+1 cycles. No pipelining.

## Test plan
All scenarios use WIDTH=8 and CHUNK=2 (N=4) unless noted.

- Basic subtract, one operation at a time:
  - sub=1, A=5, B=3 → done in cycle 5; result=0x02, carry=0, zero=0.
  - A=10, B=2 → result=0x08.
  - A=2, B=7 → result=0xFB, carry=1, negative=1, overflow=0.
- Flags:
  - Add 200+100 → result=0x2C, carry=1, overflow=0.
  - Add 0x7F+0x01 → result=0x80, overflow=1, negative=1.
  - Sub 0x80−0x01 → result=0x7F, overflow=1.
  - Sub 5−5 → result=0, zero=1, carry=0.
- Handshake:
  - `start` re-pulsed with new operands while busy=1 → ignored; first result delivered unchanged.
  - `start` held high in the DONE cycle → second operation begins; busy=1 in the next cycle; previous result stays stable until the second done.
- Reset:
  - `rst` asserted in cycle 2 of RUN → next cycle state is IDLE; busy, done, result and flags are all 0.
  - No done pulse follows.
- Configurations WIDTH=4/CHUNK=4 (N=1) and WIDTH=16/CHUNK=4:
  - 4-bit: 2−7 → result=0xB, carry=1, done 2 cycles after start.
  - 16-bit: 0x0000−0x0001 → result=0xFFFF, carry=1.

Source files
------------

// File: rtl/serial_addsub.sv
// Multi-cycle add/subtract: CHUNK bits per clock over WIDTH/CHUNK cycles, so no
// full-width carry chain is built. Registered result plus carry/borrow, overflow, zero, negative.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  // Handshake: start is taken only while busy=0 (IDLE or DONE), and A/B/sub are captured
  // on that same edge. busy stays high for N cycles. done then pulses for one cycle, and
  // result and flags are valid from that cycle until the next done.

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("serial_addsub: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sr;
  logic             cy;
  logic             sub_q;
  logic [CW-1:0]    k;

  logic [CHUNK:0]       csum;
  logic [WIDTH+CHUNK-1:0] sr_cat;
  logic [WIDTH-1:0]     sr_next;
  logic                 last_chunk;
  logic                 msb_cin;

  // Operand registers shift right each cycle, so the current chunk is always the low CHUNK bits.
  always_comb begin
    csum       = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, cy};
    sr_cat     = {csum[CHUNK-1:0], sr};
    sr_next    = sr_cat[WIDTH+CHUNK-1:CHUNK];
    last_chunk = (k == CW'(N - 1));
    // The sum bit is a ^ b ^ cin, so XOR-ing the sum bit with a and b again recovers the carry into the MSB.
    msb_cin    = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ csum[CHUNK-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sr       <= '0;
      cy       <= 1'b0;
      sub_q    <= 1'b0;
      k        <= '0;
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= A;
            b_q   <= B ^ {WIDTH{sub}};
            sub_q <= sub;
            cy    <= sub;
            k     <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_q <= a_q >> CHUNK;
          b_q <= b_q >> CHUNK;
          sr  <= sr_next;
          cy  <= csum[CHUNK];
          k   <= k + CW'(1);
          if (last_chunk) begin
            result   <= sr_next;
            carry    <= csum[CHUNK] ^ sub_q;
            overflow <= msb_cin ^ csum[CHUNK];
            zero     <= (sr_next == '0);
            negative <= sr_next[WIDTH-1];
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: 8-bit/2-bit, 4-bit/4-bit and 16-bit/4-bit instances,
// with hand-computed results, flags, handshake and reset behaviour.
module tb_serial_addsub;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 8-bit, CHUNK=2 (N=4)
  logic       st8, sb8;
  logic [7:0] a8, b8, r8;
  logic       c8, v8, z8, n8, bz8, d8;
  logic [1:0] sd8;

  // 4-bit, CHUNK=4 (N=1)
  logic       st4, sb4;
  logic [3:0] a4, b4, r4;
  logic       c4, v4, z4, n4, bz4, d4;
  logic [1:0] sd4;

  // 16-bit, CHUNK=4 (N=4)
  logic        st16, sb16;
  logic [15:0] a16, b16, r16;
  logic        c16, v16, z16, n16, bz16, d16;
  logic [1:0]  sd16;

  serial_addsub #(.WIDTH(8), .CHUNK(2)) u8 (
    .clk(clk), .rst(rst), .start(st8), .sub(sb8), .A(a8), .B(b8),
    .result(r8), .carry(c8), .overflow(v8), .zero(z8), .negative(n8),
    .busy(bz8), .done(d8), .state_dbg(sd8)
  );

  serial_addsub #(.WIDTH(4), .CHUNK(4)) u4 (
    .clk(clk), .rst(rst), .start(st4), .sub(sb4), .A(a4), .B(b4),
    .result(r4), .carry(c4), .overflow(v4), .zero(z4), .negative(n4),
    .busy(bz4), .done(d4), .state_dbg(sd4)
  );

  serial_addsub #(.WIDTH(16), .CHUNK(4)) u16 (
    .clk(clk), .rst(rst), .start(st16), .sub(sb16), .A(a16), .B(b16),
    .result(r16), .carry(c16), .overflow(v16), .zero(z16), .negative(n16),
    .busy(bz16), .done(d16), .state_dbg(sd16)
  );

  int checks   = 0;
  int failures = 0;
  int cnt;
  int done_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a start at a negedge, then poll done; cnt = cycles from the start edge to the done cycle.
  task automatic op8(input logic s, input logic [7:0] a, input logic [7:0] b, output int lat);
    st8 = 1'b1; sb8 = s; a8 = a; b8 = b;
    @(negedge clk);
    st8 = 1'b0;
    lat = 1;
    while (d8 !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic flags8(input string tag, input logic [7:0] r, input logic c, input logic v,
                        input logic z, input logic n);
    chk({tag, "_result"}, 32'(r8), 32'(r));
    chk({tag, "_carry"},  32'(c8), 32'(c));
    chk({tag, "_ovf"},    32'(v8), 32'(v));
    chk({tag, "_zero"},   32'(z8), 32'(z));
    chk({tag, "_neg"},    32'(n8), 32'(n));
  endtask

  initial begin
    rst = 1'b1;
    st8 = 0; sb8 = 0; a8 = 0; b8 = 0;
    st4 = 0; sb4 = 0; a4 = 0; b4 = 0;
    st16 = 0; sb16 = 0; a16 = 0; b16 = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy",   32'(bz8), 0);
    chk("rst_done",   32'(d8),  0);
    chk("rst_result", 32'(r8),  0);
    chk("rst_state",  32'(sd8), 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic subtract, with the latency check on the first one
    op8(1'b1, 8'd5, 8'd3, cnt);
    chk("sub5_3_latency", 32'(cnt), 5);
    chk("sub5_3_done", 32'(d8), 1);
    flags8("sub5_3", 8'h02, 0, 0, 0, 0);
    @(negedge clk);
    chk("done_pulse_one_cycle", 32'(d8), 0);
    chk("idle_after_done", 32'(sd8), 0);

    op8(1'b1, 8'd10, 8'd2, cnt);
    flags8("sub10_2", 8'h08, 0, 0, 0, 0);
    @(negedge clk);
    op8(1'b1, 8'd2, 8'd7, cnt);
    flags8("sub2_7", 8'hFB, 1, 0, 0, 1);
    @(negedge clk);

    // Flags
    op8(1'b0, 8'd200, 8'd100, cnt);
    flags8("add200_100", 8'h2C, 1, 0, 0, 0);
    @(negedge clk);
    op8(1'b0, 8'h7F, 8'h01, cnt);
    flags8("add7f_01", 8'h80, 0, 1, 0, 1);
    @(negedge clk);
    op8(1'b1, 8'h80, 8'h01, cnt);
    flags8("sub80_01", 8'h7F, 0, 1, 0, 0);
    @(negedge clk);
    op8(1'b1, 8'd5, 8'd5, cnt);
    flags8("sub5_5", 8'h00, 0, 0, 1, 0);
    @(negedge clk);

    // A start pulsed while busy must be ignored: 0x20+0x11 = 0x31
    st8 = 1'b1; sb8 = 1'b0; a8 = 8'h20; b8 = 8'h11;
    @(negedge clk);
    st8 = 1'b0;
    @(negedge clk);
    chk("busy_mid_run", 32'(bz8), 1);
    st8 = 1'b1; sb8 = 1'b1; a8 = 8'hFF; b8 = 8'h01;
    @(negedge clk);
    st8 = 1'b0;
    cnt = 3;
    while (d8 !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("ignore_start_latency", 32'(cnt), 5);
    flags8("ignore_start", 8'h31, 0, 0, 0, 0);
    @(negedge clk);
    chk("ignore_start_no_rerun", 32'(bz8), 0);

    // Back-to-back: 0x10+0x05 = 0x15, then 0x40-0x01 = 0x3F started in the DONE cycle
    op8(1'b0, 8'h10, 8'h05, cnt);
    chk("b2b_first_result", 32'(r8), 32'h15);
    st8 = 1'b1; sb8 = 1'b1; a8 = 8'h40; b8 = 8'h01;
    @(negedge clk);
    st8 = 1'b0;
    chk("b2b_busy", 32'(bz8), 1);
    chk("b2b_done_low", 32'(d8), 0);
    chk("b2b_hold_result", 32'(r8), 32'h15);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_hold_result_late", 32'(r8), 32'h15);
    cnt = 3;
    while (d8 !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("b2b_second_latency", 32'(cnt), 5);
    flags8("b2b_second", 8'h3F, 0, 0, 0, 0);
    @(negedge clk);

    // Reset in RUN cycle 2 aborts the operation and clears everything
    st8 = 1'b1; sb8 = 1'b0; a8 = 8'hC3; b8 = 8'h11;
    @(negedge clk);
    st8 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_state", 32'(sd8), 0);
    chk("abort_busy",  32'(bz8), 0);
    chk("abort_done",  32'(d8),  0);
    flags8("abort", 8'h00, 0, 0, 0, 0);
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (d8 === 1'b1) done_seen++;
    end
    chk("abort_no_done", 32'(done_seen), 0);

    // 4-bit, N=1: 2-7 = 0xB with borrow, done 2 cycles after start
    st4 = 1'b1; sb4 = 1'b1; a4 = 4'd2; b4 = 4'd7;
    @(negedge clk);
    st4 = 1'b0;
    chk("w4_busy", 32'(bz4), 1);
    cnt = 1;
    while (d4 !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("w4_latency", 32'(cnt), 2);
    chk("w4_result", 32'(r4), 32'hB);
    chk("w4_carry",  32'(c4), 1);
    chk("w4_neg",    32'(n4), 1);
    chk("w4_ovf",    32'(v4), 0);

    // 16-bit: 0x0000-0x0001 = 0xFFFF with borrow
    st16 = 1'b1; sb16 = 1'b1; a16 = 16'h0000; b16 = 16'h0001;
    @(negedge clk);
    st16 = 1'b0;
    cnt = 1;
    while (d16 !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("w16_latency", 32'(cnt), 5);
    chk("w16_result", 32'(r16), 32'hFFFF);
    chk("w16_carry",  32'(c16), 1);
    chk("w16_ovf",    32'(v16), 0);
    chk("w16_neg",    32'(n16), 1);
    chk("w16_zero",   32'(z16), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
